raster_index_gen: RTL and testbench
===================================

# raster_index_gen

Registered, parametrised raster-scan index generator that produces one (col,row) pixel coordinate per accepted transfer for the median-filter pipeline. It replaces the fixed 62x62 combinational next-index logic with runtime-configurable frame dimensions, a valid/ready handshake for downstream stalls, and single-shot or continuous frame modes. It also emits frame-position flags (start-of-frame, end-of-line, end-of-frame, window border) for the window buffer and filter core.

## Interface
- COL_W, 6, column index width
- ROW_W, 6, row index width
- WIN, 3, filter window size (odd, ≥1); border radius R = WIN/2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  terminate scan; return to IDLE
- cont_mode  in  1  1 = wrap to next frame after the last pixel; 0 = stop after one frame
- cfg_last_col  in  COL_W  last column index (width−1)
- cfg_last_row  in  ROW_W  last row index (height−1)
- out_ready  in  1  downstream accepts the current coordinate
- out_valid  out  1  col/row and flags are valid
- col  out  COL_W  current column index
- row  out  ROW_W  current row index
- sof  out  1  col==0 && row==0
- eol  out  1  col==last_col
- eof  out  1  eol && row==last_row
- border  out  1  pixel lies within R of any frame edge
- busy  out  1  state is SCAN
- done  out  1  one-cycle pulse when a single-shot frame completes

## Operation
- States: IDLE, SCAN.
- IDLE: out_valid=0. When start=1, latch cfg_last_col/cfg_last_row into internal last_col/last_row, set col=0, row=0, out_valid=1, go to SCAN.
- SCAN: a transfer occurs when out_valid && out_ready. On a transfer:
  - col<last_col: col+1, row unchanged.
  - col==last_col, row<last_row: col=0, row+1.
  - eof with cont_mode=1: col=0, row=0, re-latch cfg_*, stay in SCAN with out_valid=1.
  - eof with cont_mode=0: out_valid=0, done=1 for one cycle, go to IDLE.
- No transfer (out_ready=0): col, row and flags hold.
- cont_mode is sampled at the eof transfer only.
- abort=1 in any state: next cycle state IDLE, out_valid=0, col=row=0, done=0. abort has priority over start and over transfers.
- start in SCAN is ignored. start and abort asserted together in IDLE: abort wins, stay in IDLE.
- cfg changes during SCAN have no effect until the next latch point.
- Flags decode from the registered col/row and the latched last_*. border = col<R || col>last_col−R || row<R || row>last_row−R, computed in width+1 bits so it cannot underflow. If last_col<2R, every pixel has border=1.
- Degenerate frames: last_col=0 makes every pixel eol; last_col=last_row=0 is a 1-pixel frame with sof=eol=eof=1.
- Increments use exact width; the max index 2^W−1 is legal and never exceeded, because wrap occurs at last_*.

## Timing
- Reset: state IDLE, out_valid=0, col=0, row=0, busy=0, done=0. Flags follow their decode (sof=1), gated by out_valid at the consumer.
- start at cycle t: (0,0) is valid at t+1.
- Throughput is 1 coordinate/cycle while out_ready=1. Flags have zero added latency relative to col/row.
- Single-shot: the eof transfer at cycle t gives done=1 and out_valid=0 at t+1. The earliest new start is sampled at t+1, with (0,0) valid at t+2.
- Continuous: the eof transfer at t gives (0,0) with sof=1 at t+1, with no bubble.
- Reset mid-frame takes effect the next edge, identical to the reset values.

## Structure
- Package raster_pkg: state enum typedef (IDLE, SCAN) and default COL_W/ROW_W/WIN constants.
- Sub-module axis_wrap_counter (parametrised width): inputs inc, clr, last; outputs value, at_last. It is instantiated for col (inc=transfer) and row (inc=transfer && col at_last).

## Test plan
- Reset then start with cfg 3/2 (4x3), out_ready=1, cont_mode=0 → 12 coordinates (0,0)…(3,2) on consecutive cycles, eol at col=3, eof only on (3,2), done one cycle later, then IDLE.
- Same frame with out_ready toggling 1,0,0,1… → sequence unchanged, each coordinate held while out_ready=0, no skips or duplicates.
- cont_mode=1, cfg 1/1, with cfg changed to 2/0 mid-frame → (0,0),(1,0),(0,1),(1,1), then (0,0),(1,0),(2,0) using the new dimensions, sof on each (0,0), no gaps.
- WIN=3, cfg 4/4 → border=0 exactly for col,row ∈ {1,2,3}. With cfg 1/1 → border=1 on all pixels.
- 1-pixel frame (cfg 0/0), single-shot → one transfer with sof=eol=eof=1, then done.
- abort at pixel (2,1) with out_ready=0 → next cycle out_valid=0, (0,0), IDLE, no done. rst asserted mid-frame gives the same result. start with abort together → no start.

Source files
------------

// File: rtl/raster_index_gen_pkg.sv
// raster_pkg: shared types and default dimensions for the raster index
// generator.
//   state_t     : scan controller state (IDLE, SCAN)
//   DEF_COL_W   : default column index width
//   DEF_ROW_W   : default row index width
//   DEF_WIN     : default filter window size (odd)
package raster_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int DEF_COL_W = 6;
  localparam int DEF_ROW_W = 6;
  localparam int DEF_WIN   = 3;

endpackage

// File: rtl/raster_index_gen_if.sv
// raster_index_gen_if: coordinate stream from the index generator to the
// window buffer / filter core.
//   out_valid : coordinate and flags are valid
//   out_ready : consumer accepts the current coordinate
//   col, row  : pixel coordinate
//   sof, eol, eof, border : frame-position flags
// master = generator side, slave = consumer side.
interface raster_index_gen_if
  import raster_pkg::*;
#(
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W
);

  logic             out_valid;
  logic             out_ready;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             sof;
  logic             eol;
  logic             eof;
  logic             border;

  modport master (
    output out_valid, col, row, sof, eol, eof, border,
    input  out_ready
  );

  modport slave (
    input  out_valid, col, row, sof, eol, eof, border,
    output out_ready
  );

endinterface

// File: rtl/raster_index_gen_axis_wrap_counter.sv
// axis_wrap_counter: one axis of the raster scan. Counts 0..last and wraps
// back to 0 on an increment taken while at last.
//   clk, rst : clock, synchronous active-high reset
//   inc      : advance by one (wrapping at last)
//   clr      : force to 0 (priority over inc)
//   last     : last index of this axis
//   value    : current index
//   at_last  : value == last
module axis_wrap_counter
  import raster_pkg::*;
#(
  parameter int W = DEF_COL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] value,
  output logic         at_last
);

  logic [W-1:0] r_value;
  logic         w_at_last;

  assign w_at_last = (r_value == last);

  // Wrap happens at last, so the W-bit increment never overflows.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= w_at_last ? '0 : r_value + W'(1);
    end
  end

  assign value   = r_value;
  assign at_last = w_at_last;

endmodule

// File: rtl/raster_index_gen.sv
// raster_index_gen: registered raster-scan (col,row) generator with
// runtime frame size, valid/ready output stream and single-shot or
// continuous frame modes.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a frame (IDLE only)
//   abort        : terminate scan, back to IDLE (highest priority)
//   cont_mode    : 1 = wrap into the next frame at eof, 0 = stop
//   cfg_last_col : last column index, latched at frame start
//   cfg_last_row : last row index, latched at frame start
//   stream       : coordinate stream (out_valid/out_ready, col, row, flags)
//   busy         : scanning
//   done         : one-cycle pulse after a single-shot frame completes
module raster_index_gen
  import raster_pkg::*;
#(
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W,
  parameter int WIN   = DEF_WIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cont_mode,
  input  logic [COL_W-1:0]  cfg_last_col,
  input  logic [ROW_W-1:0]  cfg_last_row,
  raster_index_gen_if.master stream,
  output logic              busy,
  output logic              done
);

  localparam int R = WIN / 2;

  state_t           r_state;
  state_t           w_state_next;
  logic [COL_W-1:0] r_last_col;
  logic [ROW_W-1:0] r_last_row;
  logic             r_done;

  logic             w_valid;
  logic             w_start;
  logic             w_xfer;
  logic             w_eof_xfer;
  logic             w_relatch;
  logic             w_clr;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_border;

  assign w_valid    = (r_state == SCAN);
  assign w_start    = (r_state == IDLE) && start && !abort;
  assign w_xfer     = w_valid && stream.out_ready && !abort;
  assign w_eof_xfer = w_xfer && w_col_last && w_row_last;
  // Dimensions are picked up only at a frame boundary.
  assign w_relatch  = w_start || (w_eof_xfer && cont_mode);
  assign w_clr      = abort || w_start;

  axis_wrap_counter #(.W(COL_W)) u_col_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (w_xfer),
    .clr     (w_clr),
    .last    (r_last_col),
    .value   (w_col),
    .at_last (w_col_last)
  );

  axis_wrap_counter #(.W(ROW_W)) u_row_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (w_xfer && w_col_last),
    .clr     (w_clr),
    .last    (r_last_row),
    .value   (w_row),
    .at_last (w_row_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort overrides start and transfers.
  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_state_next = SCAN;
        SCAN:    if (w_eof_xfer && !cont_mode) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_col <= '0;
      r_last_row <= '0;
      r_done     <= 1'b0;
    end else begin
      if (w_relatch) begin
        r_last_col <= cfg_last_col;
        r_last_row <= cfg_last_row;
      end
      r_done <= w_eof_xfer && !cont_mode;
    end
  end

  // Border test as idx + R > last in one extra bit, which is the
  // underflow-free form of idx > last - R.
  assign w_border = ({1'b0, w_col} < (COL_W+1)'(R))
                 || (({1'b0, w_col} + (COL_W+1)'(R)) > {1'b0, r_last_col})
                 || ({1'b0, w_row} < (ROW_W+1)'(R))
                 || (({1'b0, w_row} + (ROW_W+1)'(R)) > {1'b0, r_last_row});

  // Output logic
  always_comb begin
    stream.out_valid = w_valid;
    stream.col       = w_col;
    stream.row       = w_row;
    stream.sof       = (w_col == '0) && (w_row == '0);
    stream.eol       = w_col_last;
    stream.eof       = w_col_last && w_row_last;
    stream.border    = w_border;
    busy             = w_valid;
    done             = r_done;
  end

endmodule

// File: tb/tb_raster_index_gen.sv
module tb_raster_index_gen;
  import raster_pkg::*;

  localparam int COL_W = 6;
  localparam int ROW_W = 6;
  localparam int WIN   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cont_mode = 1'b0;
  logic [COL_W-1:0] cfg_last_col = '0;
  logic [ROW_W-1:0] cfg_last_row = '0;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  raster_index_gen_if #(.COL_W(COL_W), .ROW_W(ROW_W)) stream ();

  raster_index_gen #(.COL_W(COL_W), .ROW_W(ROW_W), .WIN(WIN)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cont_mode    (cont_mode),
    .cfg_last_col (cfg_last_col),
    .cfg_last_row (cfg_last_row),
    .stream       (stream.master),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    stream.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (stream.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", stream.out_valid); end
    n_checks++; if (stream.col !== 6'd0) begin n_fail++; $display("FAIL reset_col got=%0d exp=0", stream.col); end
    n_checks++; if (stream.row !== 6'd0) begin n_fail++; $display("FAIL reset_row got=%0d exp=0", stream.row); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (stream.sof !== 1'b1) begin n_fail++; $display("FAIL reset_sof got=%b exp=1", stream.sof); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (stream.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b exp=0", stream.out_valid); end
  endtask

  // 4x3 single-shot frame at full rate; cfg is changed mid-frame and must be ignored.
  task automatic test_single_frame();
    cfg_last_col = 6'd3; cfg_last_row = 6'd2; cont_mode = 1'b0; stream.out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_last_col = 6'd1; cfg_last_row = 6'd5;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        $display("single: col=%0d row=%0d valid=%b sof=%b eol=%b eof=%b", stream.col, stream.row, stream.out_valid, stream.sof, stream.eol, stream.eof);
        n_checks++; if (stream.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", stream.out_valid); end
        n_checks++; if (stream.col !== 6'(c) || stream.row !== 6'(r)) begin n_fail++; $display("FAIL single_coord got=(%0d,%0d) exp=(%0d,%0d)", stream.col, stream.row, c, r); end
        n_checks++; if (stream.sof !== (c == 0 && r == 0)) begin n_fail++; $display("FAIL single_sof got=%b at (%0d,%0d)", stream.sof, c, r); end
        n_checks++; if (stream.eol !== (c == 3)) begin n_fail++; $display("FAIL single_eol got=%b at (%0d,%0d)", stream.eol, c, r); end
        n_checks++; if (stream.eof !== (c == 3 && r == 2)) begin n_fail++; $display("FAIL single_eof got=%b at (%0d,%0d)", stream.eof, c, r); end
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL single_busy_done got=%b/%b exp=1/0", busy, done); end
        @(negedge clk);
      end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done got=%b exp=1", done); end
    n_checks++; if (stream.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_end_idle valid=%b busy=%b exp=0/0", stream.out_valid, busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse got=%b exp=0", done); end
  endtask

  // Same frame with out_ready pattern 1,0,0 repeating.
  task automatic test_stall();
    int idx;
    int k;
    logic rdy;
    cfg_last_col = 6'd3; cfg_last_row = 6'd2; cont_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    k = 0;
    while (idx < 12 && k < 100) begin
      $display("stall: col=%0d row=%0d valid=%b", stream.col, stream.row, stream.out_valid);
      n_checks++; if (stream.out_valid !== 1'b1 || stream.col !== 6'(idx % 4) || stream.row !== 6'(idx / 4)) begin
        n_fail++; $display("FAIL stall_coord got=(%0d,%0d) v=%b exp=(%0d,%0d) v=1", stream.col, stream.row, stream.out_valid, idx % 4, idx / 4);
      end
      rdy = (k % 3 == 0);
      stream.out_ready = rdy;
      k++;
      if (rdy) idx++;
      @(negedge clk);
    end
    n_checks++; if (idx != 12) begin n_fail++; $display("FAIL stall_timeout got=%0d exp=12", idx); end
    n_checks++; if (done !== 1'b1 || stream.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_done done=%b valid=%b exp=1/0", done, stream.out_valid); end
    stream.out_ready = 1'b1;
    @(negedge clk);
  endtask

  // Continuous mode with a dimension change that applies at the frame boundary.
  task automatic test_cont();
    int ec[9] = '{0, 1, 0, 1, 0, 1, 2, 0, 1};
    int er[9] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    int ee[9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    cfg_last_col = 6'd1; cfg_last_row = 6'd1; cont_mode = 1'b1; stream.out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      $display("cont: col=%0d row=%0d sof=%b eof=%b", stream.col, stream.row, stream.sof, stream.eof);
      n_checks++; if (stream.out_valid !== 1'b1 || stream.col !== 6'(ec[i]) || stream.row !== 6'(er[i])) begin
        n_fail++; $display("FAIL cont_coord[%0d] got=(%0d,%0d) v=%b exp=(%0d,%0d) v=1", i, stream.col, stream.row, stream.out_valid, ec[i], er[i]);
      end
      n_checks++; if (stream.sof !== (ec[i] == 0 && er[i] == 0)) begin n_fail++; $display("FAIL cont_sof[%0d] got=%b", i, stream.sof); end
      n_checks++; if (stream.eof !== (ee[i] == 1)) begin n_fail++; $display("FAIL cont_eof[%0d] got=%b exp=%0d", i, stream.eof, ee[i]); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cont_done[%0d] got=%b exp=0", i, done); end
      if (i == 0) begin cfg_last_col = 6'd2; cfg_last_row = 6'd0; end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cont_mode = 1'b0;
    n_checks++; if (stream.out_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL cont_abort valid=%b done=%b exp=0/0", stream.out_valid, done); end
  endtask

  task automatic test_border();
    cfg_last_col = 6'd4; cfg_last_row = 6'd4; cont_mode = 1'b0; stream.out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        $display("border5: col=%0d row=%0d border=%b", stream.col, stream.row, stream.border);
        n_checks++; if (stream.col !== 6'(c) || stream.row !== 6'(r)) begin n_fail++; $display("FAIL border5_coord got=(%0d,%0d) exp=(%0d,%0d)", stream.col, stream.row, c, r); end
        n_checks++; if (stream.border !== !(c >= 1 && c <= 3 && r >= 1 && r <= 3)) begin n_fail++; $display("FAIL border5 got=%b at (%0d,%0d)", stream.border, c, r); end
        @(negedge clk);
      end
    end
    // Back-to-back restart on the done cycle, 2x2 frame: all border.
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL border5_done got=%b exp=1", done); end
    cfg_last_col = 6'd1; cfg_last_row = 6'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      $display("border2: col=%0d row=%0d border=%b", stream.col, stream.row, stream.border);
      n_checks++; if (stream.out_valid !== 1'b1 || stream.col !== 6'(i % 2) || stream.row !== 6'(i / 2)) begin n_fail++; $display("FAIL border2_coord got=(%0d,%0d) exp=(%0d,%0d)", stream.col, stream.row, i % 2, i / 2); end
      n_checks++; if (stream.border !== 1'b1) begin n_fail++; $display("FAIL border2 got=%b exp=1", stream.border); end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_one_pixel();
    cfg_last_col = 6'd0; cfg_last_row = 6'd0; cont_mode = 1'b0; stream.out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("one: col=%0d row=%0d sof=%b eol=%b eof=%b", stream.col, stream.row, stream.sof, stream.eol, stream.eof);
    n_checks++; if (stream.out_valid !== 1'b1) begin n_fail++; $display("FAIL one_valid got=%b exp=1", stream.out_valid); end
    n_checks++; if ({stream.sof, stream.eol, stream.eof} !== 3'b111) begin n_fail++; $display("FAIL one_flags got=%b exp=111", {stream.sof, stream.eol, stream.eof}); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || stream.out_valid !== 1'b0) begin n_fail++; $display("FAIL one_done done=%b valid=%b exp=1/0", done, stream.out_valid); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (stream.out_valid !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL one_restart valid=%b done=%b exp=1/0", stream.out_valid, done); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL one_done2 got=%b exp=1", done); end
    @(negedge clk);
  endtask

  // use_rst=0: abort at (2,1) while stalled; use_rst=1: reset at the same point.
  task automatic test_abort(input bit use_rst);
    cfg_last_col = 6'd3; cfg_last_row = 6'd2; cont_mode = 1'b0; stream.out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (stream.col !== 6'd2 || stream.row !== 6'd1) begin n_fail++; $display("FAIL abort_pos got=(%0d,%0d) exp=(2,1)", stream.col, stream.row); end
    stream.out_ready = 1'b0;
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    @(negedge clk);
    rst = 1'b0; abort = 1'b0;
    $display("abort(rst=%0d): valid=%b col=%0d row=%0d busy=%b done=%b", use_rst, stream.out_valid, stream.col, stream.row, busy, done);
    n_checks++; if (stream.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle valid=%b busy=%b exp=0/0", stream.out_valid, busy); end
    n_checks++; if (stream.col !== 6'd0 || stream.row !== 6'd0) begin n_fail++; $display("FAIL abort_coord got=(%0d,%0d) exp=(0,0)", stream.col, stream.row); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
    stream.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || stream.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_after done=%b valid=%b exp=0/0", done, stream.out_valid); end
  endtask

  task automatic test_start_abort();
    cfg_last_col = 6'd3; cfg_last_row = 6'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    $display("start+abort: valid=%b busy=%b", stream.out_valid, busy);
    n_checks++; if (stream.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL start_abort valid=%b busy=%b exp=0/0", stream.out_valid, busy); end
    @(negedge clk);
    n_checks++; if (stream.out_valid !== 1'b0) begin n_fail++; $display("FAIL start_abort_hold got=%b exp=0", stream.out_valid); end
  endtask

  initial begin
    stream.out_ready = 1'b1;
    test_reset();
    test_single_frame();
    test_stall();
    test_cont();
    test_border();
    test_one_pixel();
    test_abort(1'b0);
    test_abort(1'b1);
    test_start_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
